lfsr_range_sampler: RTL

- Downstream consumer of the 16-bit LFSR. Its rand_in port connects directly to the LFSR q_out, which supplies a new pseudo-random word every cycle.
- Converts that raw stream into an unbiased integer in [0, limit) per request, using masked rejection sampling with a bounded retry count.
- Serves game/test logic that needs dice-style values. Uses a request/response valid-ready handshake.

---
 rtl/lfsr_range_sampler.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/lfsr_range_sampler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : lfsr_range_sampler                                         |
// | Description : Turns a raw LFSR word stream into an unbiased integer in   |
// |               [0, limit) per request. It uses masked rejection sampling |
// |               with a bounded number of draws and a fold-down fallback.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk_in            in   clock, rising edge                              |
// |   rst_in            in   asynchronous active-high reset                  |
// |   rand_in           in   LFSR word, consumed once per DRAW cycle         |
// |   req_valid_in      in   request present                                 |
// |   req_limit_in      in   exclusive upper bound, sampled at acceptance    |
// |   req_ready_out     out  request accepted when high (IDLE only)          |
// |   out_valid_out     out  result valid                                    |
// |   out_ready_in      in   consumer accepts result                         |
// |   result_out        out  sampled value                                   |
// |   err_out           out  request had limit 0                             |
// |   fallback_out      out  result came from the fallback path              |
// | Optional (LFSR_RANGE_SAMPLER_STATS_EN defined)                            |
// |   tries_out         out  draws used for the current result               |
// |   total_rejects_out out  saturating count of rejected draws since reset  |
// +--------------------------------------------------------------------------+
module lfsr_range_sampler #(
  parameter int WIDTH     = 16,
  parameter int MAX_TRIES = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] rand_in,
  input  logic             req_valid_in,
  input  logic [WIDTH-1:0] req_limit_in,
  output logic             req_ready_out,
  output logic             out_valid_out,
  input  logic             out_ready_in,
  output logic [WIDTH-1:0] result_out,
  output logic             err_out,
  output logic             fallback_out
`ifdef LFSR_RANGE_SAMPLER_STATS_EN
  ,
  output logic [7:0]       tries_out,
  output logic [15:0]      total_rejects_out
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MASK = 2'd1,
    S_DRAW = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Value of the try counter on the final permitted draw (counter is pre-increment).
  localparam logic [7:0] C_LAST_TRY = 8'(MAX_TRIES - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_limit;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_result;
  logic [7:0]       r_tries;
  logic             r_err;
  logic             r_fallback;
  logic             r_out_valid;

  logic [WIDTH-1:0] w_lim_m1;
  logic [WIDTH-1:0] w_mask;
  logic             w_seen;
  logic [WIDTH-1:0] w_cand;
  logic             w_accept;
  logic             w_last;

  // Smallest all-ones mask covering limit-1: every bit at or below the
  // highest set bit of limit-1 is set.
  always_comb begin
    w_lim_m1 = r_limit - WIDTH'(1);
    w_mask   = '0;
    w_seen   = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      w_seen    = w_seen | w_lim_m1[i];
      w_mask[i] = w_seen;
    end
  end

  assign w_cand   = rand_in & r_mask;
  assign w_accept = (w_cand < r_limit);
  assign w_last   = (r_tries == C_LAST_TRY);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state     <= S_IDLE;
      r_limit     <= '0;
      r_mask      <= '0;
      r_result    <= '0;
      r_tries     <= '0;
      r_err       <= 1'b0;
      r_fallback  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid_in) begin
            r_limit <= req_limit_in;
            r_state <= S_MASK;
          end
        end
        S_MASK: begin
          r_mask  <= w_mask;
          r_tries <= '0;
          if (r_limit == '0) begin
            r_result    <= '0;
            r_err       <= 1'b1;
            r_fallback  <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_state <= S_DRAW;
          end
        end
        S_DRAW: begin
          r_tries <= r_tries + 8'd1;
          if (w_accept) begin
            r_result    <= w_cand;
            r_err       <= 1'b0;
            r_fallback  <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (w_last) begin
            // Mask is below 2*limit, so a rejected candidate folds into range.
            r_result    <= w_cand - r_limit;
            r_err       <= 1'b0;
            r_fallback  <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready_in) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready_out = (r_state == S_IDLE);
  assign out_valid_out = r_out_valid;
  assign result_out    = r_result;
  assign err_out       = r_err;
  assign fallback_out  = r_fallback;

`ifdef LFSR_RANGE_SAMPLER_STATS_EN
  logic [15:0] r_total_rejects;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_total_rejects <= '0;
    end else if ((r_state == S_DRAW) && !w_accept && (r_total_rejects != 16'hFFFF)) begin
      r_total_rejects <= r_total_rejects + 16'd1;
    end
  end

  assign tries_out         = r_tries;
  assign total_rejects_out = r_total_rejects;
`endif

endmodule
`default_nettype wire
